regfile_write_queue: RTL and testbench

Write-side front end for `register_bank`. Pipeline writeback requests arrive on a valid/ready handshake and are buffered in a small FIFO. They drain in order onto the bank's single write port (`write`/`addr_in`/`data_in`) whenever an external arbiter grants that port. The block can also forward still-queued data onto the two read paths, so readers never see stale bank contents.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/wq_fifo.sv | 71 +++++++
 rtl/regfile_write_queue.sv | 111 +++++++++++
 tb/tb_regfile_write_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write queue.
package regfile_pkg;

  localparam int unsigned ADDRESS_SIZE_DEF  = 5;
  localparam int unsigned REGISTER_SIZE_DEF = 32;

  // One queued writeback at the default bank geometry.
  typedef struct packed {
    logic [ADDRESS_SIZE_DEF-1:0]  addr;
    logic [REGISTER_SIZE_DEF-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/wq_fifo.sv
// Entry storage for the write queue: circular buffer with wrapping head/tail
// pointers and an occupancy count. Entries are also exported in age order
// (index 0 = head = oldest) so the top level can search them for forwarding.
// Build option REGFILE_WQ_BYPASS_EN also exports the queued data of every entry.
module wq_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE  = ADDRESS_SIZE_DEF,
  parameter int unsigned REGISTER_SIZE = REGISTER_SIZE_DEF,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDRESS_SIZE-1:0]    push_addr,
  input  logic [REGISTER_SIZE-1:0]   push_data,
  input  logic                       pop,
  output logic [REGISTER_SIZE-1:0]   head_data,
  output logic [ADDRESS_SIZE-1:0]    entry_addr [DEPTH],
`ifdef REGFILE_WQ_BYPASS_EN
  output logic [REGISTER_SIZE-1:0]   entry_data [DEPTH],
`endif
  output logic [DEPTH-1:0]           entry_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDRESS_SIZE-1:0]  mem_addr_q [DEPTH];
  logic [REGISTER_SIZE-1:0] mem_data_q [DEPTH];
  logic [PtrW-1:0]          head_q, tail_q;
  logic [CntW-1:0]          count_q;

  // Pointers and occupancy; reset empties the queue at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop)  head_q <= head_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: slots beyond count are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[tail_q] <= push_addr;
      mem_data_q[tail_q] <= push_data;
    end
  end

  // Rotate storage into age order and flag occupied slots.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i]  = mem_addr_q[head_q + PtrW'(i)];
`ifdef REGFILE_WQ_BYPASS_EN
      entry_data[i]  = mem_data_q[head_q + PtrW'(i)];
`endif
      entry_valid[i] = (CntW'(i) < count_q);
    end
  end

  assign head_data = mem_data_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/regfile_write_queue.sv
// Write-side front end for register_bank: buffers writeback requests, drains
// them in order when the bank write port is granted, and covers queued data on
// the two read paths. Build option REGFILE_WQ_BYPASS_EN: forward the youngest
// queued value onto rd_dataN; otherwise raise hazardN for the pipeline to stall.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE  = ADDRESS_SIZE_DEF,
  parameter int unsigned REGISTER_SIZE = REGISTER_SIZE_DEF,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDRESS_SIZE-1:0]    req_addr,
  input  logic [REGISTER_SIZE-1:0]   req_data,
  input  logic                       rf_grant,
  output logic                       write,
  output logic [ADDRESS_SIZE-1:0]    addr_in,
  output logic [REGISTER_SIZE-1:0]   data_in,
  input  logic [ADDRESS_SIZE-1:0]    addr_out1,
  input  logic [ADDRESS_SIZE-1:0]    addr_out2,
  input  logic [REGISTER_SIZE-1:0]   data_out1,
  input  logic [REGISTER_SIZE-1:0]   data_out2,
  output logic [REGISTER_SIZE-1:0]   rd_data1,
  output logic [REGISTER_SIZE-1:0]   rd_data2,
  output logic                       hazard1,
  output logic                       hazard2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       idle
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                     push, empty;
  logic [REGISTER_SIZE-1:0] head_data;
  logic [ADDRESS_SIZE-1:0]  entry_addr [DEPTH];
  logic [DEPTH-1:0]         entry_valid;
  logic                     hit1, hit2;
`ifdef REGFILE_WQ_BYPASS_EN
  logic [REGISTER_SIZE-1:0] entry_data [DEPTH];
  logic [REGISTER_SIZE-1:0] fwd1, fwd2;
`endif

  wq_fifo #(
    .ADDRESS_SIZE  (ADDRESS_SIZE),
    .REGISTER_SIZE (REGISTER_SIZE),
    .DEPTH         (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_addr   (req_addr),
    .push_data   (req_data),
    .pop         (write),
    .head_data   (head_data),
    .entry_addr  (entry_addr),
`ifdef REGFILE_WQ_BYPASS_EN
    .entry_data  (entry_data),
`endif
    .entry_valid (entry_valid),
    .count       (count)
  );

  // No pass-through when full: ready looks only at registered occupancy.
  assign empty     = (count == '0);
  assign idle      = empty;
  assign req_ready = (count != CntW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign write     = rf_grant && !empty;
  assign addr_in   = empty ? '0 : entry_addr[0];
  assign data_in   = empty ? '0 : head_data;

  // Scan oldest to youngest so the last match seen is the youngest entry.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
`ifdef REGFILE_WQ_BYPASS_EN
    fwd1 = '0;
    fwd2 = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == addr_out1)) begin
        hit1 = 1'b1;
`ifdef REGFILE_WQ_BYPASS_EN
        fwd1 = entry_data[i];
`endif
      end
      if (entry_valid[i] && (entry_addr[i] == addr_out2)) begin
        hit2 = 1'b1;
`ifdef REGFILE_WQ_BYPASS_EN
        fwd2 = entry_data[i];
`endif
      end
    end
  end

`ifdef REGFILE_WQ_BYPASS_EN
  assign rd_data1 = hit1 ? fwd1 : data_out1;
  assign rd_data2 = hit2 ? fwd2 : data_out2;
  assign hazard1  = 1'b0;
  assign hazard2  = 1'b0;
`else
  assign rd_data1 = data_out1;
  assign rd_data2 = data_out2;
  assign hazard1  = hit1;
  assign hazard2  = hit2;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue (ADDRESS_SIZE=2, REGISTER_SIZE=8,
// DEPTH=4). A queue-based reference model plus a modelled bank array supply
// all expected values; directed scenarios are followed by random traffic.
module tb_regfile_write_queue;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_ready;
  logic [1:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       rf_grant = 1'b0, write;
  logic [1:0] addr_in, addr_out1 = '0, addr_out2 = '0;
  logic [7:0] data_in, data_out1 = '0, data_out2 = '0, rd_data1, rd_data2;
  logic       hazard1, hazard2, idle;
  logic [2:0] count;

  ent_t       q[$];
  logic [7:0] bank [4];
  logic [7:0] wr_log[$];
  int         checks = 0;
  int         errors = 0;

  regfile_write_queue #(
    .ADDRESS_SIZE  (2),
    .REGISTER_SIZE (8),
    .DEPTH         (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_grant  (rf_grant),
    .write     (write),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .addr_out1 (addr_out1),
    .addr_out2 (addr_out2),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .count     (count),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected read path for one port, from the model queue and bank.
  task automatic exp_read(input logic [1:0] ra, output logic [7:0] rd, output logic hz);
    logic       hit = 1'b0;
    logic [7:0] fwd = '0;
    foreach (q[i]) if (q[i].a == ra) begin hit = 1'b1; fwd = q[i].d; end
`ifdef REGFILE_WQ_BYPASS_EN
    rd = hit ? fwd : bank[ra];
    hz = 1'b0;
`else
    rd = bank[ra];
    hz = hit;
`endif
  endtask

  task automatic check_all();
    logic [7:0] rd;
    logic       hz;
    int         sz = q.size();
    check("count", 32'(count), 32'(sz));
    check("idle", 32'(idle), 32'(sz == 0));
    check("req_ready", 32'(req_ready), 32'(sz != 4));
    check("write", 32'(write), 32'(rf_grant && sz != 0));
    check("addr_in", 32'(addr_in), sz != 0 ? 32'(q[0].a) : 32'd0);
    check("data_in", 32'(data_in), sz != 0 ? 32'(q[0].d) : 32'd0);
    exp_read(addr_out1, rd, hz);
    check("rd_data1", 32'(rd_data1), 32'(rd));
    check("hazard1", 32'(hazard1), 32'(hz));
    exp_read(addr_out2, rd, hz);
    check("rd_data2", 32'(rd_data2), 32'(rd));
    check("hazard2", 32'(hazard2), 32'(hz));
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge.
  task automatic step(input bit v, input logic [1:0] a, input logic [7:0] d, input bit g,
                      input logic [1:0] r1, input logic [1:0] r2);
    bit did_write, did_push;
    @(negedge clk);
    req_valid = v; req_addr = a; req_data = d; rf_grant = g;
    addr_out1 = r1; addr_out2 = r2;
    data_out1 = bank[r1]; data_out2 = bank[r2];
    #1;
    check_all();
    if (write) wr_log.push_back(data_in);
    did_write = g && q.size() != 0;
    did_push  = v && q.size() != 4;
    @(posedge clk);
    if (did_write) begin
      bank[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (did_push) q.push_back('{a: a, d: d});
    #1;
  endtask

  initial begin
    logic [7:0] order [5];
    order[0] = 8'h10; order[1] = 8'h11; order[2] = 8'h12; order[3] = 8'h13; order[4] = 8'h20;
    foreach (bank[i]) bank[i] = 8'h80 + 8'(i);

    // Reset state
    @(posedge clk); #1;
    check("rst_write", 32'(write), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Single write
    step(1, 2'd1, 8'hA5, 1, 0, 0);
    check("single_write", 32'(write), 32'd1);
    check("single_addr", 32'(addr_in), 32'd1);
    check("single_data", 32'(data_in), 32'hA5);
    step(0, 0, 0, 1, 0, 0);
    check("single_idle", 32'(idle), 32'd1);
    check("single_nowrite", 32'(write), 32'd0);

    // Full and wrap
    for (int i = 0; i < 4; i++) step(1, 2'(i), 8'h10 + 8'(i), 0, 0, 1);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(req_ready), 32'd0);
    step(1, 2'd0, 8'h20, 0, 0, 0);
    wr_log.delete();
    step(1, 2'd0, 8'h20, 1, 0, 0);
    step(1, 2'd0, 8'h20, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    check("wrap_len", 32'(wr_log.size()), 32'd5);
    foreach (order[i]) check("wrap_order", i < wr_log.size() ? 32'(wr_log[i]) : 32'hFFFF, 32'(order[i]));

    // Simultaneous push and pop at count 2
    step(1, 2'd1, 8'h31, 0, 1, 2);
    step(1, 2'd2, 8'h32, 0, 1, 2);
    wr_log.delete();
    for (int i = 0; i < 3; i++) begin
      step(1, 2'(i), 8'h40 + 8'(i), 1, 1, 2);
      check("simul_count", 32'(count), 32'd2);
    end
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("simul_len", 32'(wr_log.size()), 32'd5);
    check("simul_first", wr_log.size() > 0 ? 32'(wr_log[0]) : 32'hFFFF, 32'h31);
    check("simul_last", wr_log.size() > 4 ? 32'(wr_log[4]) : 32'hFFFF, 32'h42);

    // Forwarding with duplicate addresses
    bank[2] = 8'h00;
    step(1, 2'd2, 8'h11, 0, 2, 3);
    step(1, 2'd2, 8'h22, 0, 2, 3);
    step(0, 0, 0, 0, 2, 3);
`ifdef REGFILE_WQ_BYPASS_EN
    check("fwd_rd1", 32'(rd_data1), 32'h22);
    check("fwd_hz1", 32'(hazard1), 32'd0);
`else
    check("fwd_rd1", 32'(rd_data1), 32'h00);
    check("fwd_hz1", 32'(hazard1), 32'd1);
`endif
    check("fwd_hz2", 32'(hazard2), 32'd0);
    check("fwd_rd2", 32'(rd_data2), 32'(bank[3]));
    step(0, 0, 0, 1, 2, 3);
    step(0, 0, 0, 1, 2, 3);
    check("fwd_bank_last", 32'(bank[2]), 32'h22);
    check("fwd_drained", 32'(idle), 32'd1);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) step(1, 2'(i), 8'h50 + 8'(i), 0, 0, 1);
    @(negedge clk);
    req_valid = 1'b0; rf_grant = 1'b1;
    #1;
    check("mid_pre_write", 32'(write), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_write", 32'(write), 32'd0);
    check("mid_count", 32'(count), 32'd0);
    check("mid_idle", 32'(idle), 32'd1);
    check("mid_addr_in", 32'(addr_in), 32'd0);
    check("mid_data_in", 32'(data_in), 32'd0);
    q.delete();
    @(negedge clk); reset = 1'b0;
    wr_log.delete();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1);
    check("mid_no_stale", 32'(wr_log.size()), 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
           bit'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
